// File: rtl/fetch_queue.sv
// In-order instruction prefetch buffer between the PC/imem stage and decode.
// Optional alignment check on fetched PCs: define FETCH_QUEUE_MISALIGN_CHECK_EN.

module fetch_queue_entry #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PC_W-1:0]    wr_pc,
  input  logic [INSTR_W-1:0] wr_instr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);
  // Payload needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (we) begin
      pc    <= wr_pc;
      instr <= wr_instr;
    end
  end
endmodule

module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32,
  parameter int HALT_PC = 128,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   count,
  output logic               halted,
  output logic               misalign_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  HALT_V = PC_W'(HALT_PC);

  logic [AW-1:0]    rptr, wptr;
  logic [CNT_W-1:0] cnt;
  logic             halted_q;
  logic             attempt, halt_hit, drop_mis, push, pop;

  logic [DEPTH-1:0][PC_W-1:0]    pc_mem;
  logic [DEPTH-1:0][INSTR_W-1:0] instr_mem;

  assign in_ready  = (cnt != FULL) && !halted_q;
  assign out_valid = (cnt != '0);
  assign count     = cnt;
  assign halted    = halted_q;

  // A fetch that passes the handshake may still be swallowed (halt marker, misaligned PC).
  assign attempt  = in_valid && in_ready && !flush;
  assign halt_hit = attempt && (in_pc == HALT_V);
  assign push     = attempt && !halt_hit && !drop_mis;
  assign pop      = out_valid && out_ready && !flush;

`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  logic mis_q;
  assign drop_mis     = attempt && !halt_hit && (in_pc[1:0] != 2'b00);
  assign misalign_err = mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           mis_q <= 1'b0;
    else if (drop_mis) mis_q <= 1'b1;
  end
`else
  assign drop_mis     = 1'b0;
  assign misalign_err = 1'b0;
`endif

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      fetch_queue_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_ent (
        .clk      (clk),
        .we       (push && (wptr == AW'(i))),
        .wr_pc    (in_pc),
        .wr_instr (in_instr),
        .pc       (pc_mem[i]),
        .instr    (instr_mem[i])
      );
    end
  endgenerate

  assign out_pc    = out_valid ? pc_mem[rptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rptr] : '0;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           halted_q <= 1'b0;
    else if (halt_hit) halted_q <= 1'b1;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [7:0]  in_pc = 0, out_pc;
  logic [31:0] in_instr = 0, out_instr;
  logic [2:0]  count;
  logic        halted, misalign_err;

  int checks = 0, failures = 0;

  logic [39:0] m_q[$];
  bit          m_halt, m_mis;

  fetch_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .count(count), .halted(halted),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, return at the next falling edge.
  task automatic step(input logic v, input logic [7:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl, output bit acc);
    bit rdy;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    rdy = (m_q.size() < DEPTH) && !m_halt;
    acc = 0;
    if (fl) m_q.delete();
    else begin
      if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
      if (v && rdy) begin
        if (pc == 8'd128) m_halt = 1;
        else if (MIS_EN && pc[1:0] != 2'b00) m_mis = 1;
        else begin m_q.push_back({pc, ins}); acc = 1; end
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; flush = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    m_q.delete(); m_halt = 0; m_mis = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0 || out_pc !== 8'd0 || out_instr !== 32'd0) begin
      failures++; $display("FAIL reset_out got v=%b pc=%0d ins=%h exp v=0 pc=0 ins=0", out_valid, out_pc, out_instr); end
    checks++; if (halted !== 1'b0 || misalign_err !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_flags got h=%b m=%b r=%b exp 0 0 1", halted, misalign_err, in_ready); end
  endtask

  task automatic test_fill();
    bit acc;
    for (int i = 0; i < 4; i++) step(1, 8'(4*i), 32'h13 + 32'(4*i), 0, 0, acc);
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", count, in_ready); end
    checks++; if (out_pc !== 8'd0 || out_instr !== 32'h13 || out_valid !== 1'b1) begin
      failures++; $display("FAIL fill_head got pc=%0d ins=%h exp pc=0 ins=00000013", out_pc, out_instr); end
  endtask

  task automatic test_drain_full();
    bit acc, sent = 0;
    int n = 0;
    logic [7:0] exp_seq[5] = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd16};
    for (int cyc = 0; cyc < 12 && n < 5; cyc++) begin
      if (cyc == 0) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL drain_noready got=%b exp=0", in_ready); end
      end
      if (out_valid) begin
        checks++; if (out_pc !== exp_seq[n]) begin
          failures++; $display("FAIL drain_order idx=%0d got=%0d exp=%0d", n, out_pc, exp_seq[n]); end
        n++;
      end
      step(!sent, 8'd16, 32'h13 + 32'd16, 1, 0, acc);
      if (acc) sent = 1;
    end
    checks++; if (n != 5 || count !== 3'd0) begin
      failures++; $display("FAIL drain_done got popped=%0d cnt=%0d exp popped=5 cnt=0", n, count); end
  endtask

  task automatic test_push_pop_one();
    bit acc;
    step(1, 8'd32, 32'hA0, 0, 0, acc);
    for (int k = 1; k <= 10; k++) begin
      step(1, 8'(32 + 4*k), 32'hA0 + 32'(k), 1, 0, acc);
      checks++; if (count !== 3'd1 || out_pc !== 8'(32 + 4*k) || out_instr !== 32'hA0 + 32'(k)) begin
        failures++; $display("FAIL pp1 k=%0d got cnt=%0d pc=%0d exp cnt=1 pc=%0d", k, count, out_pc, 32 + 4*k); end
    end
    step(0, 0, 0, 1, 0, acc);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL pp1_drain got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    bit acc;
    for (int i = 0; i < 3; i++) step(1, 8'(40 + 4*i), 32'(i), 0, 0, acc);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", count); end
    step(1, 8'd20, 32'h20, 1, 1, acc);
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 8'd0) begin
      failures++; $display("FAIL flush_clear got cnt=%0d v=%b pc=%0d exp 0 0 0", count, out_valid, out_pc); end
    step(0, 0, 0, 0, 0, acc);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_nostore got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    bit acc;
    logic [7:0] pc;
    for (int c = 0; c < 400; c++) begin
      pc = 8'($urandom_range(0, 31) * 4);
      if ($urandom_range(0, 15) == 0) pc = pc | 8'd2;
      step($urandom_range(0, 3) != 0, pc, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 11) == 0, acc);
      checks++;
      if (count !== 3'(m_q.size()) || in_ready !== ((m_q.size() < DEPTH) && !m_halt)
          || out_valid !== (m_q.size() != 0) || misalign_err !== m_mis || halted !== m_halt) begin
        failures++;
        $display("FAIL rand_state c=%0d got cnt=%0d rdy=%b v=%b m=%b exp cnt=%0d m=%b", c, count, in_ready,
                 out_valid, misalign_err, m_q.size(), m_mis);
      end else if (m_q.size() != 0) begin
        checks++; if ({out_pc, out_instr} !== m_q[0]) begin
          failures++; $display("FAIL rand_head c=%0d got=%h exp=%h", c, {out_pc, out_instr}, m_q[0]); end
      end
    end
  endtask

  task automatic test_halt();
    bit acc;
    do_reset();
    step(1, 8'd96, 32'h96, 0, 0, acc);
    step(1, 8'd128, 32'h128, 0, 0, acc);
    checks++; if (count !== 3'd1 || halted !== 1'b1 || in_ready !== 1'b0 || out_pc !== 8'd96) begin
      failures++; $display("FAIL halt_set got cnt=%0d h=%b rdy=%b pc=%0d exp 1 1 0 96", count, halted, in_ready, out_pc); end
    step(1, 8'd100, 32'h1, 1, 0, acc);
    checks++; if (count !== 3'd0 || halted !== 1'b1) begin
      failures++; $display("FAIL halt_drain got cnt=%0d h=%b exp cnt=0 h=1", count, halted); end
    do_reset();
    checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL halt_rst got h=%b rdy=%b exp 0 1", halted, in_ready); end
  endtask

  task automatic test_misalign();
    bit acc;
    do_reset();
    step(1, 8'd6, 32'h66, 0, 0, acc);
    checks++; if (count !== (MIS_EN ? 3'd0 : 3'd1) || misalign_err !== MIS_EN || in_ready !== 1'b1) begin
      failures++; $display("FAIL misalign got cnt=%0d m=%b rdy=%b exp cnt=%0d m=%b", count, misalign_err,
                           in_ready, MIS_EN ? 0 : 1, MIS_EN); end
    if (!MIS_EN) begin
      checks++; if (out_pc !== 8'd6) begin failures++; $display("FAIL misalign_q got=%0d exp=6", out_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_full();
    test_push_pop_one();
    test_flush();
    test_random();
    test_halt();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
